// File: rtl/prio_pkg.sv
// Shared constants, mode encoding and the index-width helper used across the
// prio_req_queue design.
package prio_pkg;

    localparam int PRIO_MAX_N = 64;

    typedef enum logic {
        PRIO_FIXED = 1'b0,
        PRIO_RR    = 1'b1
    } prio_mode_e;

    // Smallest index width able to address n sources; at least one bit.
    function automatic int prio_idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit picker: reports whether any bit is set, the
// index of the highest set bit and the matching one-hot vector.
module prio_pick
    import prio_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = prio_idx_w(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    // NOTE: every output gets a default before the loops so no latch is inferred.
    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                any_o = 1'b1;
                idx_o = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = any_o && (idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/prio_req_queue.sv
// Sticky request capture with a registered valid/ready index slot; fixed priority
// by default, round-robin selectable via rr_mode when PRIO_RR_EN is defined.
module prio_req_queue
    import prio_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = prio_idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
`ifdef PRIO_RR_EN
    input  logic          rr_mode,
`endif
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic [N-1:0]  pending,
    output logic          zero
);

    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  clear_oh;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;

    logic          full_any;
    logic [IW-1:0] full_idx;
    logic [N-1:0]  full_oh;
    logic [IW-1:0] sel_idx;
    logic [N-1:0]  sel_oh;
    logic          load;

    prio_pick #(.N(N)) u_pick_full (
        .vec_i    (pending_q),
        .any_o    (full_any),
        .idx_o    (full_idx),
        .onehot_o (full_oh)
    );

`ifdef PRIO_RR_EN
    logic [IW-1:0] last_q, last_d;
    logic [N-1:0]  below_mask;
    logic [N-1:0]  masked_vec;
    logic          mask_any;
    logic [IW-1:0] mask_idx;
    logic [N-1:0]  mask_oh;

    // Bits strictly below the last grant are searched first, then the full vector wraps.
    always_comb begin
        below_mask = '0;
        for (int i = 0; i < N; i++) begin
            below_mask[i] = (i < int'(last_q));
        end
    end

    assign masked_vec = pending_q & below_mask;

    prio_pick #(.N(N)) u_pick_mask (
        .vec_i    (masked_vec),
        .any_o    (mask_any),
        .idx_o    (mask_idx),
        .onehot_o (mask_oh)
    );

    always_comb begin
        if (prio_mode_e'(rr_mode) == PRIO_RR && mask_any) begin
            sel_idx = mask_idx;
            sel_oh  = mask_oh;
        end else begin
            sel_idx = full_idx;
            sel_oh  = full_oh;
        end
    end

    assign last_d = load ? sel_idx : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= '0;
        else     last_q <= last_d;
    end
`else
    assign sel_idx = full_idx;
    assign sel_oh  = full_oh;
`endif

    assign load = (!out_valid_q || out_ready) && full_any;

    always_comb begin
        clear_oh    = '0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel_idx;
            clear_oh    = sel_oh;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A same-cycle request re-queues the bit just moved into the slot.
        pending_d = (pending_q & ~clear_oh) | req;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign zero      = (pending_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_prio_req_queue.sv
// Randomised and directed bench for prio_req_queue with a queue-based reference
// model and a grant scoreboard; exercises round-robin when PRIO_RR_EN is defined.
module tb_prio_req_queue;
    import prio_pkg::*;

    localparam int N  = 8;
    localparam int IW = prio_idx_w(N);
`ifdef PRIO_RR_EN
    localparam bit HAS_RR = 1'b1;
`else
    localparam bit HAS_RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          rr_mode;
    logic          out_ready;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic [N-1:0]  pending;
    logic          zero;

    int errors = 0;
    int checks = 0;

    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_idx;
    int         m_last;
    int         sb[$];

    always #5 clk = ~clk;

    prio_req_queue #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef PRIO_RR_EN
        .rr_mode   (rr_mode),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Search order: last-1 downward, wrapping, ending at last. Fixed priority is last = 0.
    function automatic int pick(input bit [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last - k + N) % N;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 0;
        sb.delete();
    endtask

    task automatic model_edge(input bit [N-1:0] r, input bit rdy, input bit mode);
        int g;
        if ((!m_valid || rdy) && m_pend != '0) begin
            g = pick(m_pend, (HAS_RR && mode) ? m_last : 0);
            m_pend[g] = 1'b0;
            m_valid   = 1'b1;
            m_idx     = g;
            m_last    = g;
            sb.push_back(g);
        end else if (rdy && m_valid) begin
            m_valid = 1'b0;
        end
        m_pend |= r;
    endtask

    task automatic check_state();
        check("valid",   64'(out_valid), 64'(m_valid));
        check("idx",     64'(out_idx),   64'(m_idx));
        check("pending", 64'(pending),   64'(m_pend));
        check("zero",    64'(zero),      64'(m_pend == '0 && !m_valid));
    endtask

    // Called at posedge+2: drive inputs, let one edge pass, compare at posedge+1.
    task automatic step(input bit [N-1:0] r, input bit rdy, input bit mode);
        req       = r;
        out_ready = rdy;
        rr_mode   = mode;
        @(posedge clk);
        #1;
        model_edge(r, rdy, mode);
        check_state();
        #1;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        req = '0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_pending", 64'(pending),   64'd0);
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_idx",     64'(out_idx),   64'd0);
        check("rst_zero",    64'(zero),      64'd1);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every accepted grant must be the next expected index.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_grant", 64'(out_idx), 64'hFFFF);
            end else begin
                int e;
                e = sb.pop_front();
                check("sb_grant", 64'(out_idx), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        rr_mode   = 1'b0;
        model_reset();
        #1;
        check("init_valid", 64'(out_valid), 64'd0);
        check("init_zero",  64'(zero),      64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Fixed priority: 5, 2, 0 then empty.
        step(8'b0010_0101, 1'b1, 1'b0);
        check("fx_pend", 64'(pending), 64'h25);
        step('0, 1'b1, 1'b0);
        check("fx_g0", 64'(out_idx), 64'd5);
        step('0, 1'b1, 1'b0);
        check("fx_g1", 64'(out_idx), 64'd2);
        step('0, 1'b1, 1'b0);
        check("fx_g2", 64'(out_idx), 64'd0);
        step('0, 1'b1, 1'b0);
        check("fx_zero", 64'(zero), 64'd1);

        // Backpressure: 3 held while 6 arrives, 6 follows acceptance.
        step(8'h08, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check("bp_hold", 64'(out_idx), 64'd3);
        step('0, 1'b1, 1'b0);
        check("bp_next", 64'(out_idx), 64'd6);
        step('0, 1'b1, 1'b0);

        // Re-request in the load cycle: 7 granted twice.
        step(8'h80, 1'b1, 1'b0);
        step(8'h80, 1'b1, 1'b0);
        check("rq_pend7", 64'(pending[7]), 64'd1);
        step('0, 1'b1, 1'b0);
        check("rq_second", 64'(out_idx), 64'd7);
        step('0, 1'b1, 1'b0);

`ifdef PRIO_RR_EN
        do_reset();
        step(8'hFF, 1'b1, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step(8'hFF, 1'b1, 1'b1);
            check("rr_seq", 64'(out_idx), 64'((16 - k) % 8));
        end
        for (int k = 0; k < 4; k++) begin
            step(8'hFF, 1'b1, 1'b0);
            check("rr_fixed", 64'(out_idx), 64'd7);
        end

        do_reset();
        for (int k = 0; k < 5; k++) step(8'hFF, 1'b1, 1'b1);
        check("ms_four", 64'(out_idx), 64'd4);
        step(8'hFF, 1'b1, 1'b0);
        check("ms_switch", 64'(out_idx), 64'd7);
        step('0, 1'b1, 1'b0);
`endif

        // Random traffic with a mid-run reset.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            step(N'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        for (int c = 0; c < 20; c++) step('0, 1'b1, 1'b0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("end_zero",   64'(zero),      64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_req_queue.md
# prio_req_queue

Parametrised, registered successor to the 4-input combinational priority encoder. It captures request pulses from N sources into a sticky pending vector, picks one pending source per transfer, and presents its index on a valid/ready output. Selection is fixed-priority (highest index wins) or, when compiled in, round-robin. It sits between interrupt/event sources and a single consumer that services one index at a time.

## Interface
- `N`, default 8: number of request lines; legal range 2..64.
- `IW`, default `$clog2(N)`: index width; derived, never overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N: request pulses or levels; bit i high in a cycle sets pending[i].
- `rr_mode` in 1: 0 selects fixed priority, 1 selects round-robin. Present only with `PRIO_RR_EN`.
- `out_ready` in 1: consumer accepts `out_idx` when high with `out_valid`.
- `out_valid` out 1: `out_idx` holds a granted source.
- `out_idx` out IW: index of the granted source.
- `pending` out N: registered sticky request vector, excluding the bit currently held in the output slot.
- `zero` out 1: high when `pending == 0` and `out_valid == 0`. Combinational from registers only.

## Operation
- **Reset values:**
  - `pending` = 0, `out_valid` = 0, `out_idx` = 0, `zero` = 1.
  - Round-robin pointer `last` = 0.
- **Load condition:** the output slot loads when `(!out_valid || out_ready) && pending != 0`.
  - On load, `out_idx` gets the selected index and `out_valid` = 1.
  - The selected bit is cleared from `pending`.
- **Drain:** if `out_ready && out_valid` and nothing is pending, `out_valid` goes to 0 and `out_idx` holds its value.
- **Pending update each edge:** `pending <= (pending & ~clear_onehot) | req`.
  - A set from `req` wins over a clear of the same bit in the same cycle, so the source is re-queued.
- **Fixed priority:** the highest set index of `pending` wins, matching the MSB-first priority of the existing encoder.
- **Round-robin:**
  - Search order is `last-1`, `last-2`, … descending, wrapping from 0 to N-1, ending at `last`.
  - `last` updates to the granted index on every load.
  - With `last` = 0 the order starts at N-1, identical to fixed priority after reset.
- **Mode changes:** `rr_mode` may change at any cycle. It affects only the next selection, and `last` keeps updating in both modes.
- **Multiple requests:** several `req` bits in one cycle are all captured; none are lost.
- **Repeated requests:** a request to an already-pending bit is absorbed (no counting).
- **Reset mid-transfer:** `rst` asserted at any time discards all pending and in-flight grants immediately.

## Timing
- **Latency:** a `req[i]` pulse in cycle t sets `pending[i]` at edge t+1. With the slot free, `out_valid`/`out_idx` = i is visible after edge t+2.
- **Throughput:** one grant per cycle under continuous `out_ready` = 1.
- **Handshake:** `out_idx` is stable while `out_valid && !out_ready`. `out_valid` never drops without acceptance.
- **Timing path:** no combinational path from `req` or `out_ready` to any output.

## Configuration
- **`PRIO_RR_EN` defined:** the `rr_mode` port, the `last` pointer and the rotating search are present.
- **`PRIO_RR_EN` undefined:**
  - No `rr_mode` port and no `last` register.
  - Selection is always fixed highest-index-first.
  - All other behaviour and timing are identical.

## Structure
- **Package `prio_pkg`:**
  - `PRIO_MAX_N` = 64.
  - `prio_idx_w(n)` width function.
  - Mode encoding constants `PRIO_FIXED` = 0 and `PRIO_RR` = 1.
- **Sub-module `prio_pick`:**
  - Combinational, parameter N.
  - Input vector; outputs `any`, highest-set `idx` and `onehot`.
- **Round-robin instantiation:**
  - Uses `prio_pick` on the masked vector (bits below `last`) and on the full vector.
  - Takes the masked result if it is non-zero.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> immediately `pending` = 0, `out_valid` = 0, `out_idx` = 0, `zero` = 1.
- **Fixed priority (N=8):** `req` = 8'b0010_0101 for one cycle, `out_ready` = 1 -> grants 5, 2, 0 on consecutive cycles starting 2 edges after `req`; then `zero` = 1.
- **Backpressure:** `req[3]` pulse, `out_ready` = 0 for 4 cycles -> `out_valid` = 1 with `out_idx` = 3 held stable; accepted on the first `out_ready` = 1; `req[6]` arriving meanwhile is granted next.
- **Re-request on clear:** `req[7]` asserted in the exact cycle bit 7 is loaded into the slot -> 7 granted twice in sequence; `pending[7]` = 1 after the first load.
- **Round-robin (`PRIO_RR_EN`, `rr_mode` = 1):** `req` = 8'hFF held high -> grant sequence 7, 6, 5, …, 0, 7 with no index repeated before all 8 are served; the same stimulus with `rr_mode` = 0 -> 7 every cycle.
- **Mode switch:** toggle `rr_mode` from 1 to 0 after granting 4 -> the next grant is the highest pending index regardless of `last`.
